fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the DAPA2014 core, directly upstream of the instruction register.
//  Holds the PC and fetches one 16-bit word from code memory per request, over a req/ack handshake.
//  Delivers the word to the IR as ir_data plus a one-cycle ir_w strobe.
//  Accepts branch redirects from the control unit, including redirects that arrive mid-fetch.
// PARAMETERS
//  AW        16       PC / code-memory address width
//  RESET_PC  0        PC value after reset
//  WAIT_MAX  8        max REQ cycles without mem_ack before fault (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   reset, synchronous, active-high
//  next         in   1   control unit requests next instruction (sampled in IDLE only)
//  branch       in   1   redirect PC to branch_addr
//  branch_addr  in   AW  redirect target
//  mem_req      out  1   code-memory read request (registered)
//  mem_addr     out  AW  code-memory address, stable while mem_req=1
//  mem_ack      in   1   one-cycle pulse: mem_data valid
//  mem_data     in   16  instruction word from code memory
//  ir_w         out  1   one-cycle write strobe to IR
//  ir_data      out  16  fetched word, valid when ir_w=1, held afterwards
//  pc           out  AW  address of next instruction to fetch
//  busy         out  1   state!=IDLE (combinational from state)
//  fault        out  1   sticky fetch timeout flag
// BEHAVIOUR
//  Reset values:
//   - pc=mem_addr=RESET_PC; mem_req=ir_w=fault=0; ir_data=0
//   - state=IDLE; redirect pending flag=0; wait counter=0
//  States: IDLE, REQ, GAP.
//  IDLE:
//   - next=1, fault=0: mem_addr<=(branch ? branch_addr : pc); mem_req<=1; ->REQ.
//   - branch=1, next=0: pc<=branch_addr; no fetch.
//   - next=1 while fault=1: ignored.
//  REQ, one cycle per step:
//   - wait counter starts at 0 on entry and increments each cycle with mem_ack=0.
//   - mem_ack=1, no redirect pending: ir_data<=mem_data; ir_w<=1 next cycle only;
//     pc<=mem_addr+1 (wraps mod 2^AW); mem_req<=0; ->IDLE.
//   - branch=1: set redirect pending; latch branch_addr. A later branch overwrites the target.
//     Branch and ack in the same cycle counts as pending.
//   - mem_ack=1, redirect pending: word discarded, no ir_w.
//     mem_addr<=latched target; mem_req<=0; clear pending; ->GAP.
//   - counter==WAIT_MAX-1 with mem_ack=0: fault<=1; mem_req<=0; no ir_w;
//     pending cleared; ->IDLE. An ack in that final cycle is still accepted.
//  GAP: mem_req=0 for exactly one cycle; then mem_req<=1, counter<=0; ->REQ.
//  Handshake rules:
//   - mem_ack outside REQ is ignored.
//   - mem_addr never changes while mem_req=1.
//  Latency: ack in cycle N -> ir_w=1 and busy=0 in cycle N+1.
//   - next may be asserted in cycle N+1, giving back-to-back fetches.
//  fault clears only on reset.
//  Reset mid-operation: all regs return to reset values at the next edge.
//   - mem_req=0 the following cycle; any late mem_ack is ignored; no ir_w.
// TESTING
//  1. reset; next@c0; ack@c3 data 16'hA5A5 ->
//     mem_req=1, mem_addr=0 in c1..c3; ir_w=1 only in c4; ir_data=A5A5; pc=1; busy=0 in c4.
//  2. next+branch, branch_addr=16'h0100; ack data 16'h1234 ->
//     mem_addr=0100; ir_w with 1234; pc=0101.
//  3. in REQ, branch to 16'h0200; ack 16'h1111 ->
//     no ir_w; mem_req low one cycle; refetch 0200; ack 16'h2222 -> ir_w with 2222; pc=0201.
//  4. WAIT_MAX=4, no ack ->
//     fault=1 after 4 REQ cycles; no ir_w; busy=0; next then ignored until reset.
//  5. fetch from pc=16'hFFFF ->
//     pc=16'h0000 after ir_w.
//  6. reset in 2nd REQ cycle, ack 1 cycle later ->
//     mem_req=0, no ir_w, pc=RESET_PC, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the DAPA2014 core: holds the PC, fetches one 16-bit code word
// per request over a req/ack handshake, honours mid-fetch redirects and flags fetch timeouts.
module fetch_unit #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            WAIT_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          next,
    input  logic          branch,
    input  logic [AW-1:0] branch_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data,
    output logic          ir_w,
    output logic [15:0]   ir_data,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fault
);

    // The wait counter only ever holds 0 .. WAIT_MAX-1.
    localparam int            CW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          pending;
    logic [AW-1:0] target;
    logic [CW-1:0] wait_cnt;

    logic          fetch_start;
    logic          ack_take;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          timeout;

    // A branch arriving together with the ack still counts as a redirect, and wins over
    // any target latched earlier in the same fetch.
    always_comb begin
        fetch_start   = (state == IDLE) && next && !fault;
        ack_take      = (state == REQ) && mem_ack;
        redirect      = pending || branch;
        redirect_addr = branch ? branch_addr : target;
        timeout       = (state == REQ) && !mem_ack && (wait_cnt == WAIT_LAST);
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first, so no path through the case leaves state_nxt
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_take) begin
                    state_nxt = redirect ? GAP : IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = REQ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath registers; mem_addr is only written while mem_req is low or on the
    // edge that raises it, so it is stable for the whole request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
            ir_w     <= 1'b0;
            ir_data  <= '0;
            fault    <= 1'b0;
            pending  <= 1'b0;
            target   <= '0;
            wait_cnt <= '0;
        end else begin
            ir_w <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        mem_addr <= branch ? branch_addr : pc;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                    end else if (branch) begin
                        pc <= branch_addr;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        mem_req <= 1'b0;
                        pending <= 1'b0;
                        if (redirect) begin
                            mem_addr <= redirect_addr;
                        end else begin
                            ir_data <= mem_data;
                            ir_w    <= 1'b1;
                            pc      <= mem_addr + AW'(1);
                        end
                    end else if (timeout) begin
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        pending <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        if (branch) begin
                            pending <= 1'b1;
                            target  <= branch_addr;
                        end
                    end
                end
                GAP: begin
                    mem_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model feeds expected requests and
// IR writes into queues; an independent monitor pops and compares as the DUT presents them.
module tb_fetch_unit;

    localparam int          AW       = 16;
    localparam int          WAIT_MAX = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;
    logic        ir_w;
    logic [15:0] ir_data;
    logic [15:0] pc;
    logic        busy;
    logic        fault;

    fetch_unit #(
        .AW      (AW),
        .RESET_PC(RESET_PC),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next       (next),
        .branch     (branch),
        .branch_addr(branch_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ir_w       (ir_w),
        .ir_data    (ir_data),
        .pc         (pc),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } ir_exp_t;

    ir_exp_t     ir_q[$];
    logic [15:0] req_q[$];
    logic [15:0] pc_m;
    bit          fault_m;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin : monitor
        logic        prev_req;
        logic [15:0] prev_addr;
        logic [15:0] exp_addr;
        ir_exp_t     e;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                continue;
            end
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected mem_req", 32'(mem_req), 32'(0));
                end else begin
                    exp_addr = req_q.pop_front();
                    check("mem_addr at request", 32'(mem_addr), 32'(exp_addr));
                end
            end else if (mem_req && prev_req) begin
                check("mem_addr stable", 32'(mem_addr), 32'(prev_addr));
            end
            if (mem_req) begin
                check("busy during request", 32'(busy), 32'(1));
            end
            if (ir_w) begin
                if (ir_q.size() == 0) begin
                    check("unexpected ir_w", 32'(ir_w), 32'(0));
                end else begin
                    e = ir_q.pop_front();
                    check("ir_data", 32'(ir_data), 32'(e.data));
                    check("pc after ir_w", 32'(pc), 32'(e.pc));
                    check("busy with ir_w", 32'(busy), 32'(0));
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        next    = 1'b0;
        branch  = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
        pc_m    = RESET_PC;
        fault_m = 1'b0;
        check("reset pc", 32'(pc), 32'(RESET_PC));
        check("reset mem_addr", 32'(mem_addr), 32'(RESET_PC));
        check("reset mem_req", 32'(mem_req), 32'(0));
        check("reset ir_w", 32'(ir_w), 32'(0));
        check("reset ir_data", 32'(ir_data), 32'(0));
        check("reset fault", 32'(fault), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
    endtask

    task automatic branch_idle(input logic [15:0] a);
        branch      = 1'b1;
        branch_addr = a;
        pc_m        = a;
        @(posedge clk); #1;
        branch = 1'b0;
        check("pc after idle branch", 32'(pc), 32'(pc_m));
    endtask

    // Idle cycles with random redirects and stray acks, which must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            next        = 1'b0;
            branch      = ($urandom_range(0, 3) == 0);
            branch_addr = 16'($urandom);
            mem_ack     = ($urandom_range(0, 2) == 0);
            mem_data    = 16'($urandom);
            if (branch) pc_m = branch_addr;
            @(posedge clk); #1;
            if (branch) check("pc after idle branch", 32'(pc), 32'(pc_m));
        end
        branch  = 1'b0;
        mem_ack = 1'b0;
    endtask

    // One REQ phase: ack in REQ cycle 'delay' (never if delay >= WAIT_MAX), branch in
    // cycle 'mid', plus an earlier decoy branch that the later one must override.
    task automatic run_req(input int delay, input int mid, input logic [15:0] mid_ba,
                           input logic [15:0] d, input bit decoy);
        for (int k = 0; k < WAIT_MAX; k++) begin
            mem_ack     = (k == delay);
            mem_data    = (k == delay) ? d : 16'($urandom);
            branch      = (k == mid) || (decoy && mid > 0 && k == 0);
            branch_addr = (k == mid) ? mid_ba : 16'($urandom);
            @(posedge clk); #1;
            if (k == delay) break;
        end
        mem_ack = 1'b0;
        branch  = 1'b0;
    endtask

    task automatic fetch(input bit br0, input logic [15:0] ba0, input int delay,
                         input logic [15:0] d1, input int mid, input logic [15:0] mid_ba,
                         input int delay2, input logic [15:0] d2, input bit decoy);
        logic [15:0] addr;
        logic [15:0] nxt;
        if (fault_m) begin
            next        = 1'b1;
            branch      = 1'b0;
            branch_addr = 16'($urandom);
            @(posedge clk); #1;
            next = 1'b0;
            check("busy while faulted", 32'(busy), 32'(0));
            check("fault sticky", 32'(fault), 32'(1));
            return;
        end
        addr = br0 ? ba0 : pc_m;
        req_q.push_back(addr);
        if (delay >= WAIT_MAX) begin
            fault_m = 1'b1;
        end else if (mid >= 0) begin
            req_q.push_back(mid_ba);
            if (delay2 >= WAIT_MAX) begin
                fault_m = 1'b1;
            end else begin
                nxt  = mid_ba + 16'd1;
                ir_q.push_back('{data: d2, pc: nxt});
                pc_m = nxt;
            end
        end else begin
            nxt  = addr + 16'd1;
            ir_q.push_back('{data: d1, pc: nxt});
            pc_m = nxt;
        end

        next        = 1'b1;
        branch      = br0;
        branch_addr = br0 ? ba0 : 16'($urandom);
        @(posedge clk); #1;
        next   = 1'b0;
        branch = 1'b0;
        run_req(delay, mid, mid_ba, d1, decoy);
        if (delay < WAIT_MAX && mid >= 0) begin
            check("mem_req low in GAP", 32'(mem_req), 32'(0));
            check("busy in GAP", 32'(busy), 32'(1));
            @(posedge clk); #1;
            run_req(delay2, -1, 16'h0000, d2, 1'b0);
        end
        check("fault after fetch", 32'(fault), 32'(fault_m));
        check("busy after fetch", 32'(busy), 32'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int delay;
        int delay2;
        int mid;
        #1;
        do_reset();

        // Plain fetch: ack in the third REQ cycle.
        fetch(1'b0, 16'h0000, 2, 16'hA5A5, -1, 16'h0000, 0, 16'h0000, 1'b0);
        // Fetch with simultaneous branch.
        fetch(1'b1, 16'h0100, 1, 16'h1234, -1, 16'h0000, 0, 16'h0000, 1'b0);
        // Mid-fetch redirect with an overridden earlier target.
        fetch(1'b0, 16'h0000, 3, 16'h1111, 1, 16'h0200, 1, 16'h2222, 1'b1);
        // Branch and ack in the same cycle.
        fetch(1'b0, 16'h0000, 2, 16'h3333, 2, 16'h0400, 0, 16'h4444, 1'b0);
        // PC wrap.
        branch_idle(16'hFFFF);
        fetch(1'b0, 16'h0000, 0, 16'h5555, -1, 16'h0000, 0, 16'h0000, 1'b0);
        // Ack in the last allowed cycle is accepted, back-to-back with the previous fetch.
        fetch(1'b0, 16'h0000, WAIT_MAX - 1, 16'h6666, -1, 16'h0000, 0, 16'h0000, 1'b0);
        // Timeout, then next is ignored.
        fetch(1'b0, 16'h0000, WAIT_MAX, 16'h7777, -1, 16'h0000, 0, 16'h0000, 1'b0);
        fetch(1'b0, 16'h0000, 0, 16'h8888, -1, 16'h0000, 0, 16'h0000, 1'b0);

        // Reset in the second REQ cycle, ack arriving just after.
        do_reset();
        branch_idle(16'h0777);
        req_q.push_back(pc_m);
        next = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        pc_m     = RESET_PC;
        fault_m  = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        check("mem_req after mid reset", 32'(mem_req), 32'(0));
        check("ir_w after mid reset", 32'(ir_w), 32'(0));
        check("pc after mid reset", 32'(pc), 32'(RESET_PC));
        check("fault after mid reset", 32'(fault), 32'(0));
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("ir_w after late ack", 32'(ir_w), 32'(0));
        check("mem_req after late ack", 32'(mem_req), 32'(0));

        // Randomised transactions.
        for (int i = 0; i < 80; i++) begin
            if (fault_m && $urandom_range(0, 1) == 0) do_reset();
            idle($urandom_range(0, 2));
            delay  = ($urandom_range(0, 7) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
            delay2 = ($urandom_range(0, 7) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
            mid    = ($urandom_range(0, 2) == 0)
                   ? $urandom_range(0, (delay < WAIT_MAX) ? delay : WAIT_MAX - 1) : -1;
            fetch(1'($urandom_range(0, 1)), 16'($urandom), delay, 16'($urandom),
                  mid, 16'($urandom), delay2, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        idle(3);
        check("ir queue drained", 32'(ir_q.size()), 32'(0));
        check("request queue drained", 32'(req_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
